mem_access_unit: RTL

Load/store initiator for the MEM stage of the pipeline CPU. It accepts one byte, halfword or word load/store per handshake and drives a word-wide, little-endian data memory port with one-cycle read latency. Sub-word stores are done as read-modify-write. Loads return aligned, sign- or zero-extended data. Misaligned or illegal-size requests complete with an error flag and never touch memory.

---
 rtl/mau_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 49 ++++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mau_pkg.sv
// Shared encodings and types for the MEM-stage load/store unit.
package mau_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RWAIT,
    WR,
    ERR
  } state_e;

  // Request control fields held for the life of one transaction
  typedef struct packed {
    logic              write;
    logic [SIZE_W-1:0] size;
    logic              sgn;
  } req_ctl_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane logic: alignment check, sub-word store merge and
// load extract/extend. Purely combinational.
module mem_lane_align
  import mau_pkg::*;
(
  input  logic [SIZE_W-1:0] size_i,
  input  logic [1:0]        addr_lo_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              err_c_o,
  output logic [DATA_W-1:0] merged_c_o,
  output logic [DATA_W-1:0] load_c_o
);

  logic [4:0]  byte_lsb_c;
  logic [4:0]  half_lsb_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  assign byte_lsb_c = {addr_lo_i, 3'b000};
  assign half_lsb_c = {addr_lo_i[1], 4'b0000};
  assign byte_c     = rdata_i[byte_lsb_c +: 8];
  assign half_c     = rdata_i[half_lsb_c +: 16];

  always_comb begin
    err_c_o    = 1'b0;
    merged_c_o = rdata_i;
    load_c_o   = '0;
    case (size_i)
      SZ_BYTE: begin
        merged_c_o[byte_lsb_c +: 8] = wdata_i[7:0];
        load_c_o = {{24{signed_i & byte_c[7]}}, byte_c};
      end
      SZ_HALF: begin
        err_c_o = addr_lo_i[0];
        merged_c_o[half_lsb_c +: 16] = wdata_i[15:0];
        load_c_o = {{16{signed_i & half_c[15]}}, half_c};
      end
      SZ_WORD: begin
        err_c_o    = |addr_lo_i;
        merged_c_o = wdata_i;
        load_c_o   = rdata_i;
      end
      default: err_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: one request per handshake, word-wide memory
// port with one-cycle read latency, sub-word stores via read-modify-write.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [SIZE_W-1:0] req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  req_ctl_t          ctl_q, ctl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              idle_c;
  logic [SIZE_W-1:0] al_size_c;
  logic [1:0]        al_lo_c;
  logic              al_err_c;
  logic [DATA_W-1:0] merged_c;
  logic [DATA_W-1:0] load_c;
  logic [ADDR_W-1:0] word_addr_c;

  // The single lane aligner checks the live request in IDLE, latched fields after
  assign idle_c      = (state_q == IDLE);
  assign al_size_c   = idle_c ? req_size : ctl_q.size;
  assign al_lo_c     = idle_c ? req_addr[1:0] : addr_q[1:0];
  assign word_addr_c = {addr_q[ADDR_W-1:2], 2'b00};

  mem_lane_align u_align (
    .size_i     (al_size_c),
    .addr_lo_i  (al_lo_c),
    .signed_i   (ctl_q.sgn),
    .wdata_i    (data_q),
    .rdata_i    (mem_rdata),
    .err_c_o    (al_err_c),
    .merged_c_o (merged_c),
    .load_c_o   (load_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ctl_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctl_d      = ctl_q;
    addr_d     = addr_q;
    data_d     = data_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = reset;
        if (req_valid && reset) begin
          ctl_d  = '{write: req_write, size: req_size, sgn: req_signed};
          addr_d = req_addr;
          data_d = req_wdata;
          if (al_err_c) begin
            state_d = ERR;
          end else if (!req_write || (req_size != SZ_WORD)) begin
            state_d = RD;
          end else begin
            state_d = WR;
          end
        end
      end
      RD: begin
        mem_en   = 1'b1;
        mem_addr = word_addr_c;
        state_d  = RWAIT;
      end
      // Read data arrives now: either answer the load or stage the merged word
      RWAIT: begin
        if (ctl_q.write) begin
          data_d  = merged_c;
          state_d = WR;
        end else begin
          resp_valid = 1'b1;
          resp_rdata = load_c;
          state_d    = IDLE;
        end
      end
      WR: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = word_addr_c;
        mem_wdata  = data_q;
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
